// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing constants for the FIFO read-side controller.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int SKID_DEPTH = 2;
  // Occupancy counts 0..SKID_DEPTH; credit adds the in-flight word on top.
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);
  localparam int CRD_W      = OCC_W + 1;

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Handshake bundle between the read controller, the sync FIFO and the consumer.
// FIFO_RD_STATS_EN adds the word_cnt statistics output.
interface fifo_rd_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 32
);
  logic             start;
  logic [CNT_W-1:0] rd_size;
  logic             busy;
  logic             done;
  logic             pop;
  logic             ept;
  logic [WIDTH-1:0] r_data;
  logic             valid;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             err;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]      word_cnt;
`endif

  modport master (
    input  start, rd_size, ept, r_data, valid, m_ready,
`ifdef FIFO_RD_STATS_EN
    output word_cnt,
`endif
    output busy, done, pop, m_data, m_valid, err
  );

  modport slave (
    output start, rd_size, ept, r_data, valid, m_ready,
`ifdef FIFO_RD_STATS_EN
    input  word_cnt,
`endif
    input  busy, done, pop, m_data, m_valid, err
  );
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry head/tail register FIFO; the head register drives the consumer
// stream directly so m_data/m_valid are always registered.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [OCC_W-1:0] o_occ
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             r_head_vld;
  logic             r_tail_vld;
  logic             w_deq;

  assign w_deq = r_head_vld && i_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_head_vld <= 1'b0;
      r_tail_vld <= 1'b0;
    end else if (w_deq) begin
      // Head leaves: the tail (if any) moves up, and a new push refills behind it.
      if (r_tail_vld) begin
        r_head     <= r_tail;
        r_tail_vld <= i_push;
        if (i_push) r_tail <= i_data;
      end else begin
        r_head_vld <= i_push;
        if (i_push) r_head <= i_data;
      end
    end else if (i_push) begin
      if (!r_head_vld) begin
        r_head     <= i_data;
        r_head_vld <= 1'b1;
      end else begin
        r_tail     <= i_data;
        r_tail_vld <= 1'b1;
      end
    end
  end

  assign o_data  = r_head;
  assign o_valid = r_head_vld;
  assign o_occ   = OCC_W'(r_head_vld) + OCC_W'(r_tail_vld);

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: pops the sync FIFO under a skid-buffer credit rule and
// streams words to a valid/ready consumer. FIFO_RD_STATS_EN adds word_cnt.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 32
) (
  input  logic           clock,
  input  logic           reset,
  fifo_rd_ctrl_if.master bus
);

  rd_state_e        r_state;
  rd_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_remaining_nxt;
  logic             r_inflight;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             w_pop;
  logic             w_done_nxt;
  logic             w_push;
  logic             w_deq;
  logic             w_m_valid;
  logic [OCC_W-1:0] w_occ;
  logic [CRD_W-1:0] w_credit;
  logic [CRD_W-1:0] w_limit;

  assign w_deq    = w_m_valid && bus.m_ready;
  assign w_push   = bus.valid && r_inflight;
  // occ + inflight - deq < depth, rearranged so nothing underflows.
  assign w_credit = CRD_W'(w_occ) + CRD_W'(r_inflight);
  assign w_limit  = CRD_W'(SKID_DEPTH) + CRD_W'(w_deq);

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_pop           = 1'b0;
    w_done_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.rd_size != '0) begin
            w_state_nxt     = RUN;
            w_remaining_nxt = bus.rd_size;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        w_pop = !bus.ept && (r_remaining != '0) && (w_credit < w_limit);
        if (w_pop) begin
          w_remaining_nxt = r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1)) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_inflight && (w_occ == '0)) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_inflight  <= w_pop;
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= w_done_nxt;
      // A return with nothing outstanding is dropped and flagged until reset.
      if (bus.valid && !r_inflight) r_err <= 1'b1;
    end
  end

  fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (bus.r_data),
    .i_ready (bus.m_ready),
    .o_data  (bus.m_data),
    .o_valid (w_m_valid),
    .o_occ   (w_occ)
  );

  assign bus.m_valid = w_m_valid;
  assign bus.pop     = w_pop;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;

`ifdef FIFO_RD_STATS_EN
  logic [31:0] r_word_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     r_word_cnt <= '0;
    else if (w_deq) r_word_cnt <= r_word_cnt + 32'd1;
  end

  assign bus.word_cnt = r_word_cnt;
`endif

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the team's synchronous FIFO: it drains a commanded burst of `rd_size` words by issuing `pop`, captures the FIFO's `r_data`/`valid` return, and presents the words to the consumer on a valid/ready stream. It sits directly downstream of the sync FIFO. It replaces the bench-side pop driving with synthesizable flow control that never overruns the consumer and never pops an empty FIFO.

## Interface
Parameters:
- `WIDTH`, 8, data word width; must match the FIFO's `Width`.
- `CNT_W`, 32, width of `rd_size` and the remaining-words counter.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle burst request; sampled only in IDLE.
- `rd_size`  in  CNT_W  burst length in words; latched when `start` is accepted.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when a burst completes.
- `pop`  out  1  FIFO read strobe.
- `ept`  in  1  FIFO empty flag.
- `r_data`  in  WIDTH  FIFO read data; valid when `valid` is high.
- `valid`  in  1  FIFO read-return strobe, exactly 1 cycle after an accepted `pop`.
- `m_data`  out  WIDTH  word to the consumer.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  consumer accepts the word when both `m_valid` and `m_ready` are high.
- `err`  out  1  sticky protocol error; cleared only by reset.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - `start` with `rd_size != 0` -> RUN; `remaining <= rd_size`.
  - `start` with `rd_size == 0` -> `done` pulses the next cycle; the FSM stays in IDLE.
- RUN:
  - `pop = !ept && remaining != 0 && (occ + inflight - (m_valid && m_ready)) < 2`.
  - `occ` is the skid-buffer occupancy (0..2). `inflight` is high for one cycle after a `pop`.
  - Each `pop` decrements `remaining`. When `remaining` reaches 0 on a pop, the FSM goes to DRAIN.
- DRAIN: when `inflight == 0` and `occ == 0` -> IDLE, with `done` pulsing during that transition cycle.
- `start` while `busy` is ignored. A new burst may start in the cycle after `done`.
- A `valid` with `inflight == 0` sets `err`. That data is discarded.
- `valid` with `inflight == 1` writes `r_data` into the skid buffer. The credit rule guarantees that the buffer never overflows.
- Output order matches pop order (FIFO semantics). The buffer can enqueue and dequeue in the same cycle.
- `ept` high in RUN stalls without error. The burst resumes when `ept` drops.

## Timing
- Reset values: `busy`=0, `done`=0, `pop`=0, `m_valid`=0, `m_data`=0, `err`=0. FSM resets to IDLE, `remaining`=0, `occ`=0.
- `pop` is combinational from registered state, `ept`, and `m_ready`. All other outputs are registered.
- Latency:
  - `start` -> first `pop`: 1 cycle (the cycle after `start`, if `ept` = 0).
  - `pop` -> `valid`: 1 cycle.
  - `valid` -> `m_valid`: 1 cycle.
  - Start to first word at the consumer: 3 cycles.
- Throughput is 1 word/cycle with `m_ready` held high and the FIFO non-empty.
- If `reset` is asserted mid-burst, all state is dropped immediately. Words already popped are lost. The FIFO's own reset is expected alongside it.

## Configuration
- `FIFO_RD_STATS_EN`:
  - When defined: adds output `word_cnt` [31:0]. It is reset to 0, increments on every `m_valid && m_ready`, wraps at 2^32, and is not cleared by `start`.
  - When undefined: the port and counter do not exist; all other behaviour is identical.

## Structure
- Package `fifo_rd_pkg` holds:
  - the `rd_state_e` enum (IDLE/RUN/DRAIN);
  - localparam `SKID_DEPTH` = 2;
  - the occupancy/credit width constants.
- Sub-module `fifo_rd_skid`: a 2-entry register FIFO with push/pop, `occ` output, and `m_data`/`m_valid` drive. The top holds the FSM, the counter, and the `err` logic.

## Test plan
- Burst of 4 with the FIFO preloaded 0x11..0x14 and `m_ready`=1 -> 4 back-to-back pops; `m_data` is 0x11..0x14 on consecutive cycles starting 3 cycles after `start`; `done` pulses once; `busy` then drops.
- `start` with `rd_size`=0 -> no `pop`, `done` high 1 cycle later, `busy` never rises.
- Burst of 6 with `m_ready` toggling 1,0,0,1 repeating -> `occ` never exceeds 2, no word is lost or duplicated, order is preserved, and `done` follows the 6th handshake.
- Burst of 3 with the FIFO holding 1 word, the other 2 pushed 10 cycles later -> `pop` is held low while `ept`=1, `err` stays 0, and all 3 words are delivered.
- Inject a `valid` with no prior `pop`; also assert `reset` mid-burst of 8 after 3 words -> `err` goes 1 and stays 1; after reset, all outputs are 0, the FSM is in IDLE, and a fresh burst of 2 completes normally.
- With `FIFO_RD_STATS_EN`, run two bursts of 5 -> `word_cnt` = 10.
